// File: rtl/fetch_sequencer.sv
// Dual-issue fetch sequencer: owns the fetch PC, queues {pc, inst0, inst1} pairs for decode,
// and applies branch redirects with flush. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int          ADDR_W    = 11,
  parameter int          BUF_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst0,
  input  logic [31:0]       imem_inst1,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [ADDR_W-1:0] pair_pc,
  output logic [31:0]       pair_inst0,
  output logic [31:0]       pair_inst1,
  output logic              pair_slot0_ok,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_pairs,
  output logic [31:0]       perf_stalls,
`endif
  output logic              fetch_busy
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
  logic [31:0]       i0_mem   [BUF_DEPTH];
  logic [31:0]       i1_mem   [BUF_DEPTH];
  logic              ok_mem   [BUF_DEPTH];

  logic enq;
  logic deq;
  logic unused_pc_bits;

  // Low address bits only matter for the slot-kill flag (bit 2); the rest is word offset.
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign imem_addr     = pc;
  assign pair_valid    = (count != '0);
  assign fetch_busy    = (state == S_RUN);
  assign pair_pc       = pc_mem[rd_ptr];
  assign pair_inst0    = i0_mem[rd_ptr];
  assign pair_inst1    = i1_mem[rd_ptr];
  assign pair_slot0_ok = ok_mem[rd_ptr];

  // Fullness uses the pre-dequeue count, so a full FIFO never enqueues even while popping.
  assign enq = !reset && !redirect_valid && (state == S_RUN) && (count < DEPTH_C);
  assign deq = !reset && !redirect_valid && pair_valid && pair_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= PC_INIT;
      kill   <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      state  <= S_RUN;
      pc     <= {redirect_pc[ADDR_W-1:3], 3'b000};
      kill   <= redirect_pc[2];
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (state == S_IDLE && start)
        state <= S_RUN;
      else if (state == S_RUN && halt)
        state <= S_HALT;

      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc + ADDR_W'(8);
        kill   <= 1'b0;
      end
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;

      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr] <= pc;
      i0_mem[wr_ptr] <= imem_inst0;
      i1_mem[wr_ptr] <= imem_inst1;
      ok_mem[wr_ptr] <= !kill;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters; a stall is a RUN cycle where the full FIFO blocks fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_pairs  <= '0;
      perf_stalls <= '0;
    end else begin
      if (enq && perf_pairs != '1)
        perf_pairs <= perf_pairs + 1'b1;
      if (!redirect_valid && state == S_RUN && count == DEPTH_C && perf_stalls != '1)
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer plus hand-written latency/reset sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [10:0] redirect_pc = '0;
  logic [10:0] imem_addr;
  logic [31:0] imem_inst0;
  logic [31:0] imem_inst1;
  logic        pair_valid;
  logic        pair_ready = 1'b0;
  logic [10:0] pair_pc;
  logic [31:0] pair_inst0;
  logic [31:0] pair_inst1;
  logic        pair_slot0_ok;
  logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_pairs;
  logic [31:0] perf_stalls;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem0(input logic [10:0] a);
    return 32'hA500_0000 | {21'b0, a};
  endfunction

  function automatic logic [31:0] mem1(input logic [10:0] a);
    logic [10:0] b;
    b = a + 11'd4;
    return 32'h5B00_0000 | {21'b0, b};
  endfunction

  assign imem_inst0 = mem0(imem_addr);
  assign imem_inst1 = mem1(imem_addr);

  fetch_sequencer #(.ADDR_W(11), .BUF_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_inst0(imem_inst0), .imem_inst1(imem_inst1),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_pc(pair_pc),
    .pair_inst0(pair_inst0), .pair_inst1(pair_inst1), .pair_slot0_ok(pair_slot0_ok),
`ifdef FETCH_PERF_CNT_EN
    .perf_pairs(perf_pairs), .perf_stalls(perf_stalls),
`endif
    .fetch_busy(fetch_busy)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        hl;
    logic        rv;
    logic [10:0] rpc;
    logic        rdy;
    logic        ev;
    logic [10:0] epc;
    logic        eok;
    logic [10:0] eaddr;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, st, hl, rv, input logic [10:0] rpc,
                              input logic rdy, ev, input logic [10:0] epc,
                              input logic eok, input logic [10:0] eaddr, input logic ebusy);
    vec_t v;
    v.rst = rst; v.st = st; v.hl = hl; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eok = eok; v.eaddr = eaddr; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic checkVal(input string name, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, hl, rv, input logic [10:0] rpc, input logic rdy);
    reset = rst; start = st; halt = hl; redirect_valid = rv; redirect_pc = rpc;
    pair_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.rst, v.st, v.hl, v.rv, v.rpc, v.rdy);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal("pair_valid", idx, {31'b0, pair_valid}, {31'b0, v.ev});
    checkVal("imem_addr", idx, {21'b0, imem_addr}, {21'b0, v.eaddr});
    checkVal("fetch_busy", idx, {31'b0, fetch_busy}, {31'b0, v.ebusy});
    if (v.ev) begin
      checkVal("pair_pc", idx, {21'b0, pair_pc}, {21'b0, v.epc});
      checkVal("pair_inst0", idx, pair_inst0, mem0(v.epc));
      checkVal("pair_inst1", idx, pair_inst1, mem1(v.epc));
      checkVal("pair_slot0_ok", idx, {31'b0, pair_slot0_ok}, {31'b0, v.eok});
    end
  endtask

  initial begin
    int cycles;

    //                rst st hl rv rpc     rdy ev epc     ok addr    busy
    vecs.push_back(mk(1, 0, 0, 0, 11'h0,   0, 0, 11'h0,   1, 11'h000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 11'h0,   1, 0, 11'h0,   1, 11'h000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h000, 1, 11'h008, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h008, 1, 11'h010, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h010, 1, 11'h018, 1));
    // Back-pressure: four pairs fill the FIFO, then fetch stalls at 0x20.
    vecs.push_back(mk(1, 0, 0, 0, 11'h0,   0, 0, 11'h0,   1, 11'h000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 11'h0,   0, 0, 11'h0,   1, 11'h000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   0, 1, 11'h000, 1, 11'h008, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   0, 1, 11'h000, 1, 11'h010, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   0, 1, 11'h000, 1, 11'h018, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   0, 1, 11'h000, 1, 11'h020, 1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 0, 0, 11'h0, 0, 1, 11'h000, 1, 11'h020, 1));
    // Full FIFO popped: no enqueue that cycle, refill on the next.
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h008, 1, 11'h020, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   0, 1, 11'h008, 1, 11'h028, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h010, 1, 11'h028, 1));
    // Redirect into odd word with 3 entries held.
    vecs.push_back(mk(0, 0, 0, 1, 11'h044, 1, 0, 11'h0,   1, 11'h040, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   0, 1, 11'h040, 0, 11'h048, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h048, 1, 11'h050, 1));
    // Halt with two entries, drain, then redirect restarts.
    vecs.push_back(mk(0, 0, 1, 0, 11'h0,   0, 1, 11'h048, 1, 11'h058, 0));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h050, 1, 11'h058, 0));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 0, 11'h0,   1, 11'h058, 0));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 0, 11'h0,   1, 11'h058, 0));
    vecs.push_back(mk(0, 0, 0, 1, 11'h100, 1, 0, 11'h0,   1, 11'h100, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h100, 1, 11'h108, 1));
    // Redirect beats halt, then PC wraps past 0x7F8.
    vecs.push_back(mk(0, 0, 1, 1, 11'h7F0, 1, 0, 11'h0,   1, 11'h7F0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h7F0, 1, 11'h7F8, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h7F8, 1, 11'h000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11'h0,   1, 1, 11'h000, 1, 11'h008, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Start-to-valid latency, bounded wait.
    drive(1, 0, 0, 0, 11'h0, 1);
    drive(0, 1, 0, 0, 11'h0, 1);
    cycles = 1;
    start = 1'b0;
    while (!pair_valid && cycles < 8) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkVal("start_latency", 100, cycles, 2);
    checkVal("first_pc", 100, {21'b0, pair_pc}, 32'h0);

    // Reset while full mid-stream.
    drive(0, 0, 0, 0, 11'h0, 0);
    for (int k = 0; k < 5; k++)
      drive(0, 0, 0, 0, 11'h0, 0);
    checkVal("full_valid", 101, {31'b0, pair_valid}, 32'h1);
    checkVal("full_addr", 101, {21'b0, imem_addr}, 32'h20);
    drive(1, 0, 0, 0, 11'h0, 1);
    checkVal("rst_valid", 102, {31'b0, pair_valid}, 32'h0);
    checkVal("rst_addr", 102, {21'b0, imem_addr}, 32'h0);
    checkVal("rst_busy", 102, {31'b0, fetch_busy}, 32'h0);
    for (int k = 0; k < 3; k++)
      drive(0, 0, 1, 0, 11'h0, 1);
    checkVal("idle_valid", 103, {31'b0, pair_valid}, 32'h0);
    checkVal("idle_busy", 103, {31'b0, fetch_busy}, 32'h0);
    checkVal("idle_addr", 103, {21'b0, imem_addr}, 32'h0);
    drive(0, 1, 0, 0, 11'h0, 1);
    checkVal("restart_busy", 104, {31'b0, fetch_busy}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
